// File: rtl/clk_divider_multi_pkg.sv
// Shared defaults and rate constants for the multi-channel clock divider.
package clk_divider_multi_pkg;

  localparam int unsigned     DefCntW  = 38;
  localparam int unsigned     DefNumCh = 2;
  localparam longint unsigned DefLimit = 200000;

  // Board clock the named rate constants below are derived for.
  localparam longint unsigned ClkInHz = 100_000_000;

  // The output period is 2*(limit+1) input cycles, so limit = clk/(2*out) - 1.
  function automatic longint unsigned limit_for_hz(input longint unsigned clk_hz,
                                                   input longint unsigned out_hz);
    return clk_hz / (2 * out_hz) - 1;
  endfunction

  localparam longint unsigned Limit1kHz  = limit_for_hz(ClkInHz, 1000);  // display scan
  localparam longint unsigned Limit250Hz = limit_for_hz(ClkInHz, 250);   // keypad debounce
  localparam longint unsigned Limit1Hz   = limit_for_hz(ClkInHz, 1);     // lock timeout

endpackage

// File: rtl/clk_divider_multi_if.sv
// Control/status bundle for clk_divider_multi; the controller drives via master.
interface clk_divider_multi_if #(
  parameter int unsigned NumCh = 2,
  parameter int unsigned CntW  = 38
);
  logic [NumCh-1:0]      en;
  logic [NumCh-1:0]      restart;
  logic [NumCh-1:0]      limit_wr;
  logic [NumCh*CntW-1:0] limit_in;
  logic [NumCh-1:0]      divided_clk;
  logic [NumCh-1:0]      tick;
  logic [NumCh-1:0]      limit_pend;

  modport master (
    output en, restart, limit_wr, limit_in,
    input  divided_clk, tick, limit_pend
  );

  modport slave (
    input  en, restart, limit_wr, limit_in,
    output divided_clk, tick, limit_pend
  );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active limit, toggle flop and tick strobe.
module clk_div_channel
  import clk_divider_multi_pkg::*;
#(
  parameter int unsigned      CNT_W     = DefCntW,
  parameter logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(DefLimit)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             limit_wr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             divided_clk_o,
  output logic             tick_o,
  output logic             limit_pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             terminal;

  // >= rather than == so a limit shrunk below the running count ends the half-period at once.
  assign terminal = (cnt_q >= active_q);

  // Next-state: restart beats enable; limit adoption only at terminal or restart.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    pend_d   = pend_q;

    if (restart_i) begin
      cnt_d = '0;
      div_d = 1'b0;
      if (limit_wr_i) begin
        // A write alongside restart takes effect immediately and never shows as pending.
        active_d = limit_i;
        shadow_d = limit_i;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
      end
    end else begin
      if (en_i) begin
        if (terminal) begin
          cnt_d  = '0;
          div_d  = ~div_q;
          tick_d = 1'b1;
          if (pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A write in a terminal cycle stays pending until the following terminal.
      if (limit_wr_i) begin
        shadow_d = limit_i;
        pend_d   = 1'b1;
      end
    end
  end

  // State registers; reset discards any pending limit.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= DEF_LIMIT;
      shadow_q <= DEF_LIMIT;
      div_q    <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign divided_clk_o = div_q;
  assign tick_o        = tick_q;
  assign limit_pend_o  = pend_q;

endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH independent run-time programmable clock dividers off a single clock.
// divided_clk is a registered data signal; downstream logic should key off tick.
module clk_divider_multi
  import clk_divider_multi_pkg::*;
#(
  parameter int unsigned      CNT_W     = DefCntW,
  parameter int unsigned      NUM_CH    = DefNumCh,
  parameter logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(DefLimit)
) (
  input logic               clk_in,
  input logic               rst_n,
  clk_divider_multi_if.slave bus
);

  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  // One channel per bit; channel k owns limit_in[k*CNT_W +: CNT_W].
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_channel #(
      .CNT_W     (CNT_W),
      .DEF_LIMIT (DEF_LIMIT)
    ) u_ch (
      .clk_in        (clk_in),
      .rst_n         (rst_n),
      .en_i          (bus.en[k]),
      .restart_i     (bus.restart[k]),
      .limit_wr_i    (bus.limit_wr[k]),
      .limit_i       (bus.limit_in[k*CNT_W +: CNT_W]),
      .divided_clk_o (div_clk[k]),
      .tick_o        (tick[k]),
      .limit_pend_o  (pend[k])
    );
  end

  assign bus.divided_clk = div_clk;
  assign bus.tick        = tick;
  assign bus.limit_pend  = pend;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi with DEF_LIMIT overridden to 4.
module tb_clk_divider_multi;
  localparam int unsigned CntW  = 38;
  localparam int unsigned NumCh = 2;

  logic clk_in;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  clk_divider_multi_if #(.NumCh(NumCh), .CntW(CntW)) bus ();

  clk_divider_multi #(
    .CNT_W     (CntW),
    .NUM_CH    (NumCh),
    .DEF_LIMIT (38'd4)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_div;
    logic [1:0] exp_tick;

    rst_n         = 1'b0;
    bus.en        = '0;
    bus.restart   = '0;
    bus.limit_wr  = '0;
    bus.limit_in  = '0;

    // Reset values
    cyc();
    cyc();
    check("rst_div",  bus.divided_clk, 2'b00);
    check("rst_tick", bus.tick,        2'b00);
    check("rst_pend", bus.limit_pend,  2'b00);

    // Limit 4, both enabled: tick every 5 cycles, first on cycle 5, period 10
    rst_n  = 1'b1;
    bus.en = 2'b11;
    exp_div = 2'b00;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      exp_tick = (n % 5 == 0) ? 2'b11 : 2'b00;
      if (n % 5 == 0) exp_div = ~exp_div;
      check($sformatf("t1_tick_n%0d", n), bus.tick, exp_tick);
      check($sformatf("t1_div_n%0d", n), bus.divided_clk, exp_div);
    end

    // Limit 0 on ch0, written at cnt 0: adopted at the terminal 5 edges later
    bus.limit_wr = 2'b01;
    bus.limit_in[0 +: CntW] = 38'd0;
    cyc();  // e21
    bus.limit_wr = 2'b00;
    check("t2_pend_set", bus.limit_pend, 2'b01);
    cyc(); cyc(); cyc();  // e24
    check("t2_pend_hold", bus.limit_pend, 2'b01);
    check("t2_tick_e24", bus.tick, 2'b00);
    cyc();  // e25
    check("t2_tick_e25", bus.tick, 2'b11);
    check("t2_div_e25", bus.divided_clk, 2'b11);
    check("t2_pend_clr", bus.limit_pend, 2'b00);
    for (int e = 26; e <= 34; e++) begin
      cyc();
      exp_div  = {((e < 30) ? 1'b1 : 1'b0), ((e % 2 == 1) ? 1'b1 : 1'b0)};
      exp_tick = {((e == 30) ? 1'b1 : 1'b0), 1'b1};
      check($sformatf("t2_div_e%0d", e), bus.divided_clk, exp_div);
      check($sformatf("t2_tick_e%0d", e), bus.tick, exp_tick);
    end

    // Restart both with a simultaneous write of limit 4: resync, nothing pending
    bus.restart  = 2'b11;
    bus.limit_wr = 2'b11;
    bus.limit_in[0 +: CntW]    = 38'd4;
    bus.limit_in[CntW +: CntW] = 38'd4;
    cyc();  // r0
    bus.restart  = 2'b00;
    bus.limit_wr = 2'b00;
    check("r0_div",  bus.divided_clk, 2'b00);
    check("r0_tick", bus.tick,        2'b00);
    check("r0_pend", bus.limit_pend,  2'b00);
    for (int r = 1; r <= 5; r++) begin
      cyc();
      check($sformatf("r_tick_r%0d", r), bus.tick, (r == 5) ? 2'b11 : 2'b00);
    end
    check("r5_div", bus.divided_clk, 2'b11);

    // Limit 9 on ch0 written at cnt 1: this half-period stays 5, next ones 10
    cyc();  // r6
    bus.limit_wr = 2'b01;
    bus.limit_in[0 +: CntW] = 38'd9;
    cyc();  // r7
    bus.limit_wr = 2'b00;
    check("t3_pend_r7", bus.limit_pend, 2'b01);
    cyc(); cyc();  // r9
    check("t3_pend_r9", bus.limit_pend, 2'b01);
    check("t3_tick_r9", bus.tick, 2'b00);
    cyc();  // r10
    check("t3_tick_r10", bus.tick, 2'b11);
    check("t3_pend_r10", bus.limit_pend, 2'b00);
    check("t3_div_r10", bus.divided_clk, 2'b00);
    for (int r = 11; r <= 30; r++) begin
      cyc();
      exp_tick = {((r % 5 == 0) ? 1'b1 : 1'b0), ((r == 20 || r == 30) ? 1'b1 : 1'b0)};
      check($sformatf("t3_tick_r%0d", r), bus.tick, exp_tick);
      if (r == 20) check("t3_div_r20", bus.divided_clk, 2'b01);
      if (r == 30) check("t3_div_r30", bus.divided_clk, 2'b00);
    end

    // ch0 back to limit 4, then hold en[0] low for 7 cycles at cnt 2
    bus.restart  = 2'b01;
    bus.limit_wr = 2'b01;
    bus.limit_in[0 +: CntW] = 38'd4;
    cyc();  // s0
    bus.restart  = 2'b00;
    bus.limit_wr = 2'b00;
    check("t4_div0_s0",  {1'b0, bus.divided_clk[0]}, 2'b00);
    check("t4_pend0_s0", {1'b0, bus.limit_pend[0]},  2'b00);
    cyc(); cyc();  // s2, cnt0 = 2
    bus.en = 2'b10;
    for (int s = 3; s <= 9; s++) begin
      cyc();
      check($sformatf("t4_tick0_s%0d", s), {1'b0, bus.tick[0]}, 2'b00);
      check($sformatf("t4_div0_s%0d", s),  {1'b0, bus.divided_clk[0]}, 2'b00);
    end
    bus.en = 2'b11;
    cyc();
    check("t4_tick0_s10", {1'b0, bus.tick[0]}, 2'b00);
    cyc();
    check("t4_tick0_s11", {1'b0, bus.tick[0]}, 2'b00);
    cyc();
    check("t4_tick0_s12", {1'b0, bus.tick[0]}, 2'b01);
    check("t4_div0_s12",  {1'b0, bus.divided_clk[0]}, 2'b01);

    // Restart ch1 with a simultaneous write of limit 2
    bus.restart  = 2'b10;
    bus.limit_wr = 2'b10;
    bus.limit_in[CntW +: CntW] = 38'd2;
    cyc();  // t0
    bus.restart  = 2'b00;
    bus.limit_wr = 2'b00;
    check("t5_div1_t0",  {1'b0, bus.divided_clk[1]}, 2'b00);
    check("t5_tick1_t0", {1'b0, bus.tick[1]},        2'b00);
    check("t5_pend1_t0", {1'b0, bus.limit_pend[1]},  2'b00);
    for (int t = 1; t <= 3; t++) begin
      cyc();
      check($sformatf("t5_tick1_t%0d", t), {1'b0, bus.tick[1]}, (t == 3) ? 2'b01 : 2'b00);
      check($sformatf("t5_pend1_t%0d", t), {1'b0, bus.limit_pend[1]}, 2'b00);
    end
    check("t5_div1_t3", {1'b0, bus.divided_clk[1]}, 2'b01);

    // Write on ch0 in its terminal cycle: old limit used, new one pending
    bus.limit_wr = 2'b01;
    bus.limit_in[0 +: CntW] = 38'd7;
    cyc();  // t4
    bus.limit_wr = 2'b00;
    check("t6_tick0_t4", {1'b0, bus.tick[0]},        2'b01);
    check("t6_div0_t4",  {1'b0, bus.divided_clk[0]}, 2'b00);
    check("t6_pend0_t4", {1'b0, bus.limit_pend[0]},  2'b01);

    // Asynchronous reset mid-count: outputs clear without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_div",  bus.divided_clk, 2'b00);
    check("t6_rst_tick", bus.tick,        2'b00);
    check("t6_rst_pend", bus.limit_pend,  2'b00);
    cyc();
    rst_n = 1'b1;
    exp_div = 2'b00;
    for (int u = 1; u <= 10; u++) begin
      cyc();
      exp_tick = (u % 5 == 0) ? 2'b11 : 2'b00;
      if (u % 5 == 0) exp_div = ~exp_div;
      check($sformatf("t6_tick_u%0d", u), bus.tick, exp_tick);
      check($sformatf("t6_div_u%0d", u), bus.divided_clk, exp_div);
    end
    check("t6_pend_after", bus.limit_pend, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
